// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared definitions for the alarm controller slice: the 2-bit FSM state
// enumeration, default moduli for the alarm minute/hour registers, the
// seconds-counter width and a small modular increment helper.
package alarm_pkg;

    localparam int MIN_N_DEF = 60;
    localparam int HRS_N_DEF = 24;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

    // Advance a 7-bit time field by one, wrapping to zero at modulus n.
    // Any out-of-range value also wraps to zero so the register recovers.
    function automatic logic [6:0] wrapInc(input logic [6:0] v, input int n);
        if (int'(v) >= n - 1) begin
            return 7'd0;
        end
        return v + 7'd1;
    endfunction

endpackage

// File: rtl/alarm_ctrl_sec_dcount.sv
// sec_dcount
// Loadable seconds down-counter used as the snooze timer. A load takes
// priority over counting; each enabled cycle (one per second tick)
// decrements the count, which holds at zero rather than wrapping.
//
// Ports
//   i_clk      system clock, all updates on the rising edge
//   i_rst      synchronous active-high reset, clears the count
//   i_load     load i_load_val into the counter
//   i_load_val value to load
//   i_en       decrement enable (seconds tick)
//   o_zero     count is zero
//   o_one      count is one (the next enabled tick reaches zero)
module sec_dcount
    import alarm_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl
// Alarm clock controller: stores the alarm time, compares it with the
// running time of day and sequences IDLE / ARMED / RINGING / SNOOZE.
// The ring timeout counter and FSM live here; the snooze timer is the
// sec_dcount sub-module.
//
// Ports
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_sec_tick            one-cycle pulse per time-of-day second
//   i_t_sec/min/hrs       current time of day
//   i_set_min, i_set_hrs  pulses advancing the alarm minute / hour
//   i_alarm_on            level, alarm armed while high
//   i_snooze, i_stop      user pulses
//   o_a_min, o_a_hrs      stored alarm time
//   o_buzz                high while ringing
//   o_state               current FSM state encoding
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int MIN_N      = MIN_N_DEF,
    parameter int HRS_N      = HRS_N_DEF,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sec_tick,
    input  logic [6:0] i_t_sec,
    input  logic [6:0] i_t_min,
    input  logic [6:0] i_t_hrs,
    input  logic       i_set_min,
    input  logic       i_set_hrs,
    input  logic       i_alarm_on,
    input  logic       i_snooze,
    input  logic       i_stop,
    output logic [6:0] o_a_min,
    output logic [6:0] o_a_hrs,
    output logic       o_buzz,
    output logic [1:0] o_state
);

    localparam logic [CNT_W-1:0] RING_LIMIT = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNZ_LOAD   = CNT_W'(SNOOZE_SEC);

    alarm_state_t     r_state;
    alarm_state_t     w_state_next;
    logic [6:0]       r_a_min;
    logic [6:0]       r_a_hrs;
    logic [CNT_W-1:0] r_ring_cnt;
    logic             w_match;
    logic             w_ring_timeout;
    logic             w_ring_count;
    logic             w_ring_enter;
    logic             w_snz_load;
    logic             w_snz_en;
    logic             w_snz_zero;
    logic             w_snz_one;

    // Alarm time registers; edits are accepted in every state and the
    // minute never carries into the hour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_min <= 7'd0;
            r_a_hrs <= 7'd0;
        end else begin
            if (i_set_min) begin
                r_a_min <= wrapInc(r_a_min, MIN_N);
            end
            if (i_set_hrs) begin
                r_a_hrs <= wrapInc(r_a_hrs, HRS_N);
            end
        end
    end

    // A match only exists on the tick that lands on second zero of the
    // alarm minute, so it happens once per minute at most.
    assign w_match = i_sec_tick && (i_t_sec == 7'd0) &&
                     (i_t_min == r_a_min) && (i_t_hrs == r_a_hrs);

    // Ring counting only happens in RINGING when no higher-priority input
    // (alarm off, stop, snooze) is taking the FSM elsewhere.
    assign w_ring_count   = (r_state == ST_RINGING) && i_alarm_on &&
                            !i_stop && !i_snooze && i_sec_tick;
    assign w_ring_timeout = w_ring_count && (r_ring_cnt >= RING_LIMIT - CNT_W'(1));
    assign w_ring_enter   = (w_state_next == ST_RINGING) && (r_state != ST_RINGING);

    assign w_snz_load = (r_state == ST_RINGING) && i_alarm_on && !i_stop && i_snooze;
    assign w_snz_en   = (r_state == ST_SNOOZE) && i_sec_tick;

    sec_dcount #(
        .W (CNT_W)
    ) u_snooze_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_snz_load),
        .i_load_val (SNZ_LOAD),
        .i_en       (w_snz_en),
        .o_zero     (w_snz_zero),
        .o_one      (w_snz_one)
    );

    // Ring second counter: cleared on every entry to RINGING, then counts
    // ticks up to RING_SEC and holds there.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ring_cnt <= '0;
        end else if (w_ring_enter) begin
            r_ring_cnt <= '0;
        end else if (w_ring_count && (r_ring_cnt < RING_LIMIT)) begin
            r_ring_cnt <= r_ring_cnt + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Dropping alarm_on overrides everything, applied
    // last so it wins; within RINGING/SNOOZE stop beats snooze beats the
    // timers. The snooze expiry also fires from a zero count so the FSM
    // can never stall in SNOOZE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_alarm_on) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_match) begin
                    w_state_next = ST_RINGING;
                end
            end
            ST_RINGING: begin
                if (i_stop) begin
                    w_state_next = ST_ARMED;
                end else if (i_snooze) begin
                    w_state_next = ST_SNOOZE;
                end else if (w_ring_timeout) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_SNOOZE: begin
                if (i_stop) begin
                    w_state_next = ST_ARMED;
                end else if (i_sec_tick && (w_snz_one || w_snz_zero)) begin
                    w_state_next = ST_RINGING;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (!i_alarm_on) begin
            w_state_next = ST_IDLE;
        end
    end

    assign o_a_min = r_a_min;
    assign o_a_hrs = r_a_hrs;
    assign o_buzz  = (r_state == ST_RINGING);
    assign o_state = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl
// Directed bench for alarm_ctrl with hand-computed expected values:
// alarm time setting and wrap, ring on match, ring timeout, snooze
// countdown, stop/snooze priority, alarm-off override, edits while
// ringing and reset in the middle of a ring.
module tb_alarm_ctrl;

    logic       clk;
    logic       rst;
    logic       sec_tick;
    logic [6:0] t_sec;
    logic [6:0] t_min;
    logic [6:0] t_hrs;
    logic       set_min;
    logic       set_hrs;
    logic       alarm_on;
    logic       snooze;
    logic       stop;
    logic [6:0] a_min;
    logic [6:0] a_hrs;
    logic       buzz;
    logic [1:0] state;

    int nChecks = 0;
    int nPassed = 0;

    localparam int IDLE    = 0;
    localparam int ARMED   = 1;
    localparam int RINGING = 2;
    localparam int SNOOZE  = 3;

    alarm_ctrl #(
        .MIN_N      (60),
        .HRS_N      (24),
        .SNOOZE_SEC (300),
        .RING_SEC   (60)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sec_tick (sec_tick),
        .i_t_sec    (t_sec),
        .i_t_min    (t_min),
        .i_t_hrs    (t_hrs),
        .i_set_min  (set_min),
        .i_set_hrs  (set_hrs),
        .i_alarm_on (alarm_on),
        .i_snooze   (snooze),
        .i_stop     (stop),
        .o_a_min    (a_min),
        .o_a_hrs    (a_hrs),
        .o_buzz     (buzz),
        .o_state    (state)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; return 1 unit after the rising edge so inputs can
    // be changed and outputs sampled away from the edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        if (observed == expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setTime(input int s, input int m, input int h);
        t_sec = 7'(s);
        t_min = 7'(m);
        t_hrs = 7'(h);
    endtask

    // Pulse a named one-cycle input n times, one clock each.
    task automatic applyStimulus(input string what, input int n);
        for (int i = 0; i < n; i++) begin
            case (what)
                "set_min": set_min  = 1'b1;
                "set_hrs": set_hrs  = 1'b1;
                "snooze":  snooze   = 1'b1;
                "stop":    stop     = 1'b1;
                "tick":    sec_tick = 1'b1;
                default:   $display("[TB] unknown stimulus %s", what);
            endcase
            stepCycle();
            set_min  = 1'b0;
            set_hrs  = 1'b0;
            snooze   = 1'b0;
            stop     = 1'b0;
            sec_tick = 1'b0;
        end
    endtask

    // Put the time on hh:mm:00 and tick once to produce a match.
    task automatic ringAt(input int m, input int h);
        setTime(0, m, h);
        applyStimulus("tick", 1);
        setTime(10, m, h);
    endtask

    initial begin
        rst      = 1'b1;
        sec_tick = 1'b0;
        set_min  = 1'b1;
        set_hrs  = 1'b1;
        alarm_on = 1'b0;
        snooze   = 1'b0;
        stop     = 1'b0;
        setTime(0, 0, 0);

        // Reset held together with set pulses: registers stay cleared.
        stepCycle();
        stepCycle();
        checkOutput("rst_state", state, IDLE);
        checkOutput("rst_a_min", a_min, 0);
        checkOutput("rst_a_hrs", a_hrs, 0);
        checkOutput("rst_buzz", buzz, 0);
        set_min = 1'b0;
        set_hrs = 1'b0;
        rst     = 1'b0;
        stepCycle();

        // Alarm time setting and minute wrap without hour carry.
        applyStimulus("set_hrs", 7);
        applyStimulus("set_min", 30);
        checkOutput("set_a_hrs_7", a_hrs, 7);
        checkOutput("set_a_min_30", a_min, 30);
        applyStimulus("set_min", 30);
        checkOutput("wrap_a_min_0", a_min, 0);
        checkOutput("wrap_a_hrs_7", a_hrs, 7);
        applyStimulus("set_min", 30);
        checkOutput("restore_a_min_30", a_min, 30);
        applyStimulus("set_hrs", 17);
        checkOutput("hrs_wrap_0", a_hrs, 0);
        applyStimulus("set_hrs", 7);
        checkOutput("hrs_back_7", a_hrs, 7);

        // IDLE ignores everything until alarm_on.
        applyStimulus("tick", 1);
        checkOutput("idle_hold", state, IDLE);
        alarm_on = 1'b1;
        stepCycle();
        checkOutput("armed", state, ARMED);

        // 07:29:59 then match on 07:30:00 tick.
        setTime(59, 29, 7);
        applyStimulus("tick", 1);
        checkOutput("no_match_2959", state, ARMED);
        setTime(0, 30, 7);
        stepCycle();
        checkOutput("match_no_tick_state", state, ARMED);
        checkOutput("match_no_tick_buzz", buzz, 0);
        sec_tick = 1'b1;
        #1;
        checkOutput("buzz_during_match", buzz, 0);
        stepCycle();
        sec_tick = 1'b0;
        checkOutput("ring_state", state, RINGING);
        checkOutput("ring_buzz", buzz, 1);

        // Ring timeout after 60 ticks.
        setTime(5, 30, 7);
        applyStimulus("tick", 59);
        checkOutput("ring_59", state, RINGING);
        applyStimulus("tick", 1);
        checkOutput("timeout_state", state, ARMED);
        checkOutput("timeout_buzz", buzz, 0);

        // Snooze countdown of 300 seconds.
        ringAt(30, 7);
        checkOutput("ring2_state", state, RINGING);
        applyStimulus("snooze", 1);
        checkOutput("snooze_state", state, SNOOZE);
        checkOutput("snooze_buzz", buzz, 0);
        applyStimulus("snooze", 1);
        checkOutput("snooze_ignored", state, SNOOZE);
        applyStimulus("tick", 299);
        checkOutput("snooze_299", state, SNOOZE);
        applyStimulus("tick", 1);
        checkOutput("snooze_end_state", state, RINGING);
        checkOutput("snooze_end_buzz", buzz, 1);

        // Ring counter restarted after snooze: 59 ticks still ringing.
        applyStimulus("tick", 59);
        checkOutput("rering_59", state, RINGING);

        // stop and snooze together: stop wins.
        stop   = 1'b1;
        snooze = 1'b1;
        stepCycle();
        stop   = 1'b0;
        snooze = 1'b0;
        checkOutput("stop_over_snooze", state, ARMED);

        // Stop inside SNOOZE returns to ARMED.
        ringAt(30, 7);
        applyStimulus("snooze", 1);
        applyStimulus("stop", 1);
        checkOutput("stop_in_snooze", state, ARMED);

        // alarm_on low during SNOOZE forces IDLE, no ring afterwards.
        ringAt(30, 7);
        applyStimulus("snooze", 1);
        checkOutput("snooze_again", state, SNOOZE);
        alarm_on = 1'b0;
        stop     = 1'b1;
        stepCycle();
        stop     = 1'b0;
        checkOutput("off_to_idle", state, IDLE);
        ringAt(30, 7);
        checkOutput("off_no_ring_state", state, IDLE);
        checkOutput("off_no_ring_buzz", buzz, 0);

        // Alarm edits during RINGING keep the state.
        alarm_on = 1'b1;
        stepCycle();
        checkOutput("rearm", state, ARMED);
        ringAt(30, 7);
        applyStimulus("set_min", 1);
        checkOutput("edit_ring_state", state, RINGING);
        checkOutput("edit_ring_a_min", a_min, 31);
        applyStimulus("stop", 1);
        checkOutput("edit_stop", state, ARMED);

        // Reset in the middle of a ring.
        ringAt(31, 7);
        checkOutput("ring_31", state, RINGING);
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst_state", state, IDLE);
        checkOutput("midrst_buzz", buzz, 0);
        checkOutput("midrst_a_min", a_min, 0);
        checkOutput("midrst_a_hrs", a_hrs, 0);
        rst = 1'b0;
        stepCycle();
        checkOutput("post_rst_armed", state, ARMED);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter: MIN_N, 60, minute modulus for the alarm-minute register.
REQ-002 Parameter: HRS_N, 24, hour modulus for the alarm-hour register.
REQ-003 Parameter: SNOOZE_SEC, 300, snooze duration in seconds (1..65535).
REQ-004 Parameter: RING_SEC, 60, auto-stop ring timeout in seconds (1..65535).
REQ-005 clk  in  1  single system clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 sec_tick  in  1  one-cycle pulse marking each time-of-day seconds advance.
REQ-008 t_sec, t_min, t_hrs  in  7 each  current time-of-day counts from the seconds/minutes/hours counters.
REQ-009 set_min, set_hrs  in  1 each  one-cycle pulses advancing the alarm minute/hour.
REQ-010 alarm_on  in  1  level; alarm armed when high.
REQ-011 snooze, stop  in  1 each  one-cycle user pulses.
REQ-012 a_min, a_hrs  out  7 each  stored alarm time.
REQ-013 buzz  out  1  high while ringing.
REQ-014 state  out  2  current FSM state encoding.

Function
REQ-015 The block SHALL hold a_min/a_hrs registers; set_min SHALL update a_min to (a_min+1)%MIN_N, set_hrs SHALL update a_hrs to (a_hrs+1)%HRS_N, next cycle, in every state; no carry from minute to hour.
REQ-016 The block SHALL implement FSM states IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-017 match SHALL be sec_tick && t_sec==0 && t_min==a_min && t_hrs==a_hrs (combinational, evaluated on current register values).
REQ-018 IDLE -> ARMED when alarm_on=1; all other inputs ignored in IDLE.
REQ-019 ARMED -> RINGING on match; ring second counter SHALL be cleared on entry.
REQ-020 RINGING: stop -> ARMED; else snooze -> SNOOZE with snooze counter loaded to SNOOZE_SEC; else ring counter increments on each sec_tick and, on the sec_tick where it would reach RING_SEC, -> ARMED.
REQ-021 SNOOZE: stop -> ARMED; snooze counter decrements on each sec_tick; on the sec_tick where it reaches 0 -> RINGING with ring counter cleared; snooze pulses in SNOOZE ignored.
REQ-022 alarm_on=0 SHALL force next state IDLE from any state, with priority over every other input.
REQ-023 Priority within RINGING/SNOOZE: alarm_on=0 > stop > snooze > timer events.
REQ-024 buzz SHALL be decoded from the state register: 1 iff state==RINGING; transition to RINGING occurs the cycle after the triggering match, so buzz rises 1 cycle after match.
REQ-025 Alarm-time edits during RINGING or SNOOZE SHALL not change the current state; a new match SHALL only be acted on in ARMED.
REQ-026 Return to ARMED after stop or timeout SHALL not retrigger in the same minute, since t_sec==0 with sec_tick recurs only once per minute.
REQ-027 Counters SHALL be 16-bit unsigned, no wrap: ring counter saturates at RING_SEC, snooze counter stops at 0.

Reset
REQ-028 On rst: state=IDLE, a_min=0, a_hrs=0, ring and snooze counters=0, buzz=0; rst SHALL override all inputs, including set pulses and mid-ring/mid-snooze operation.
REQ-029 In the first cycle after rst deasserts, the FSM SHALL evaluate alarm_on normally.

Structure
REQ-030 A shared package alarm_pkg SHALL define the state enum (2-bit) and the MIN_N/HRS_N defaults.
REQ-031 One sub-module sec_dcount (loadable 16-bit seconds down-counter with zero flag, enabled by sec_tick) SHALL implement the snooze timer; the ring counter and FSM stay in alarm_ctrl.

Verification
REQ-032 rst, set_hrs x7, set_min x30 -> a_hrs=7, a_min=30; set_min x30 more -> a_min=0, a_hrs=7.
REQ-033 alarm_on=1, alarm 07:30, drive time 07:29:59 then sec_tick to 07:30:00 and sec_tick -> state=RINGING, buzz=1 exactly 1 cycle after match; 60 further sec_ticks -> state=ARMED, buzz=0.
REQ-034 RINGING, snooze pulse -> SNOOZE, buzz=0; 299 sec_ticks -> still SNOOZE; 300th -> RINGING, buzz=1.
REQ-035 RINGING with stop and snooze in same cycle -> ARMED; alarm_on=0 during SNOOZE -> IDLE; no ring at next 07:30:00 while alarm_on=0.
REQ-036 rst asserted mid-RINGING -> state=IDLE, buzz=0, a_min=a_hrs=0 next cycle.
REQ-037 ARMED, match with sec_tick=0 (time held at 07:30:00 without tick) -> stays ARMED, buzz=0.
